seq_alu: RTL and testbench

Parametrised, registered ALU with an integrated iterative multiply/divide unit and HI/LO registers. It replaces the purely combinational execute-stage ALU in the multi-cycle datapath. It keeps that ALU's 15 single-cycle operations and adds MULT/MULTU/DIV/DIVU plus HI/LO moves. A valid/ready handshake lets the control FSM stall while a long operation runs.

---
 rtl/seq_alu.sv | 204 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Registered ALU with an iterative shift-add multiplier and a
//             restoring divider writing the HI/LO registers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   localparam int SH_W = CNT_W - 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, bmag_q, bmag_d, aorig_q, aorig_d;
   logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d, div_zero_q, div_zero_d;

   logic [SH_W-1:0]    shamt;
   logic [WIDTH-1:0]   alu_res;
   logic               long_op, op_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign shamt     = a[SH_W-1:0];
   assign long_op   = (op[4:2] == 3'b100);
   assign op_signed = ~op[0];
   assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

   always_comb begin
      alu_res = a;
      case (op)
         5'h00, 5'h08: alu_res = a + b;
         5'h01, 5'h09: alu_res = a - b;
         5'h02:        alu_res = a & b;
         5'h03:        alu_res = a | b;
         5'h04:        alu_res = a ^ b;
         5'h05:        alu_res = ~(a | b);
         5'h06:        alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         5'h07:        alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         5'h0A:        alu_res = b << shamt;
         5'h0B:        alu_res = b << (WIDTH / 2);
         5'h0C:        alu_res = b >> shamt;
         5'h0D:        alu_res = $signed(b) >>> shamt;
         5'h0E:        alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         5'h14:        alu_res = hi_q;
         5'h15:        alu_res = lo_q;
         default:      alu_res = a;
      endcase
   end

   // Datapath for one multiply/divide step; the same acc/mq pair holds
   // {product high, product low} or {remainder, dividend/quotient}.
   assign mul_sum   = {1'b0, acc_q} + {1'b0, bmag_q};
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, bmag_q});
   assign prod_fix  = neg_lo_q ? -{acc_q, mq_q} : {acc_q, mq_q};
   assign quot_fix  = neg_lo_q ? -mq_q : mq_q;
   assign rem_fix   = neg_hi_q ? -acc_q : acc_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      hi_d        = hi_q;
      lo_d        = lo_q;
      acc_d       = acc_q;
      mq_d        = mq_q;
      bmag_d      = bmag_q;
      aorig_d     = aorig_q;
      is_div_d    = is_div_q;
      neg_lo_d    = neg_lo_q;
      neg_hi_d    = neg_hi_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (long_op) begin
                  state_d    = ITER;
                  cnt_d      = '0;
                  acc_d      = '0;
                  mq_d       = a_mag;
                  bmag_d     = b_mag;
                  aorig_d    = a;
                  is_div_d   = op[1];
                  neg_lo_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi_d   = op_signed & op[1] & a[WIDTH-1];
                  div_zero_d = op[1] & (b == '0);
               end else begin
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  out_valid_d = 1'b1;
                  if (op == 5'h16) hi_d = a;
                  if (op == 5'h17) lo_d = a;
               end
            end
         end
         ITER: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            if (!is_div_q) begin
               if (mq_q[0]) {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
               else         {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
            end else if (div_ge) begin
               acc_d = div_shift[WIDTH-1:0] - bmag_q;
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = div_shift[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
         end
         DONE: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (div_zero_q) begin
               hi_d = aorig_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
            result_d    = lo_d;
            zero_d      = (lo_d == '0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         acc_q       <= '0;
         mq_q        <= '0;
         bmag_q      <= '0;
         aorig_q     <= '0;
         is_div_q    <= 1'b0;
         neg_lo_q    <= 1'b0;
         neg_hi_q    <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         acc_q       <= acc_d;
         mq_q        <= mq_d;
         bmag_q      <= bmag_d;
         aorig_q     <= aorig_d;
         is_div_q    <= is_div_d;
         neg_lo_q    <= neg_lo_d;
         neg_hi_q    <= neg_hi_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Directed and randomized checks of seq_alu against an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [4:0]   op = 5'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, zero;
   logic [W-1:0] result, hi, lo;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
      .zero(zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: architectural effect of one operation, by plain arithmetic.
   task automatic ref_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] h_in, input logic [W-1:0] l_in,
                         output logic [W-1:0] h, output logic [W-1:0] l,
                         output logic [W-1:0] r, output bit lng);
      longint          sp;
      longint unsigned up;
      int              sx, sy;
      logic [4:0]      sh;
      sh = x[4:0];
      h = h_in; l = l_in; r = x; lng = 0;
      case (o)
         5'h00, 5'h08: r = x + y;
         5'h01, 5'h09: r = x - y;
         5'h02: r = x & y;
         5'h03: r = x | y;
         5'h04: r = x ^ y;
         5'h05: r = ~(x | y);
         5'h06: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         5'h07: r = (x < y) ? 32'd1 : 32'd0;
         5'h0A: r = y << sh;
         5'h0B: r = y << 16;
         5'h0C: r = y >> sh;
         5'h0D: r = $signed(y) >>> sh;
         5'h0E: r = (x == y) ? 32'd1 : 32'd0;
         5'h14: r = h_in;
         5'h15: r = l_in;
         5'h16: h = x;
         5'h17: l = x;
         5'h10: begin sp = longint'($signed(x)) * longint'($signed(y)); {h, l} = sp; lng = 1; end
         5'h11: begin up = 64'(x) * 64'(y); {h, l} = up; lng = 1; end
         5'h12, 5'h13: begin
            lng = 1;
            if (y == '0) begin
               l = '1; h = x;
            end else if (o == 5'h12 && x == MIN && y == '1) begin
               l = MIN; h = '0;
            end else if (o == 5'h12) begin
               sx = int'(x); sy = int'(y);
               l = sx / sy; h = sx % sy;
            end else begin
               l = x / y; h = x % y;
            end
         end
         default: r = x;
      endcase
      if (lng) r = l;
   endtask

   logic [W-1:0] m_hi, m_lo, m_res, p_hi, p_lo, t_hi, t_lo, t_r;
   bit           m_zero, m_valid, model_ok, t_lng;
   int           busy = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_hi = '0; m_lo = '0; m_res = '0; m_zero = 1; m_valid = 0; busy = 0;
         model_ok = 1;
      end else if (model_ok) begin
         m_valid = 0;
         if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_res = p_lo; m_zero = (p_lo == '0); m_valid = 1;
            end
         end else if (in_valid) begin
            ref_op(op, a, b, m_hi, m_lo, t_hi, t_lo, t_r, t_lng);
            if (t_lng) begin
               p_hi = t_hi; p_lo = t_lo; busy = W + 1;
            end else begin
               m_hi = t_hi; m_lo = t_lo; m_res = t_r; m_zero = (t_r == '0); m_valid = 1;
            end
         end
      end
   end

   int           vcyc[$];
   logic [W-1:0] vres[$];
   logic         vzero[$];
   int           run_low = 0;
   int           last_low = 0;

   always @(negedge clk) begin
      if (model_ok) begin
         chk1("out_valid", out_valid, m_valid);
         chk1("in_ready", in_ready, busy == 0);
         chk("result", result, m_res);
         chk1("zero", zero, m_zero);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         if (out_valid) begin
            vcyc.push_back(cyc); vres.push_back(result); vzero.push_back(zero);
         end
         if (!in_ready) run_low++;
         else begin
            if (run_low != 0) last_low = run_low;
            run_low = 0;
         end
      end
   end

   task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int acc_cyc);
      op = o; a = x; b = y; in_valid = 1'b1;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      if (!in_ready) chk1("issue_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int n_target);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (vres.size() >= n_target) begin ok = 1; break; end
      end
      if (!ok) chk1("done_timeout", out_valid, 1'b1);
   endtask

   task automatic run(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output int lat);
      int n0, k;
      n0 = vres.size();
      issue(o, x, y, k);
      wait_valid(n0 + 1);
      lat = (vcyc.size() > n0) ? vcyc[$] - k : -1;
   endtask

   logic [4:0] ops_tab [0:25] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                  5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
                                  5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17,
                                  5'h18, 5'h1F};

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return MIN;
         3: return W'($urandom_range(0, 20));
         4: return -W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   int k, lat, n0;

   initial begin
      @(negedge clk);
      #1;
      chk("rst_result", result, 32'd0);
      chk1("rst_zero", zero, 1'b1);
      chk("rst_hi", hi, 32'd0);
      chk1("rst_ready", in_ready, 1'b1);
      rst = 1'b0;

      // Abort a multiply by reset in the middle of its iterations.
      run(5'h16, 32'h55, 32'h0, lat);
      issue(5'h10, 32'd7, 32'd9, k);
      while (cyc < k + 10) @(posedge clk);
      n0 = vres.size();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk1("abort_ready", in_ready, 1'b1);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_valid", W'(vres.size()), W'(n0));

      // Three back-to-back single-cycle ops.
      n0 = vres.size();
      issue(5'h00, 32'd5, -32'd3, k);
      issue(5'h07, 32'd1, 32'hFFFF_FFFF, k);
      issue(5'h0D, 32'd4, MIN, k);
      wait_valid(n0 + 3);
      if (vres.size() >= n0 + 3) begin
         chk("b2b_add", vres[n0], 32'd2);
         chk("b2b_sltu", vres[n0+1], 32'd1);
         chk("b2b_sra", vres[n0+2], 32'hF800_0000);
         chk1("b2b_zero", vzero[n0] | vzero[n0+1] | vzero[n0+2], 1'b0);
         chk("b2b_consec1", W'(vcyc[n0+1] - vcyc[n0]), 32'd1);
         chk("b2b_consec2", W'(vcyc[n0+2] - vcyc[n0+1]), 32'd1);
      end

      run(5'h10, 32'hFFFF_FFFF, 32'd2, lat);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      chk("mult_latency", W'(lat), 32'd33);
      chk("mult_ready_low", W'(last_low), 32'd33);
      run(5'h11, 32'hFFFF_FFFF, 32'd2, lat);
      chk("multu_hi", hi, 32'd1);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      run(5'h12, -32'd7, 32'd2, lat);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run(5'h13, 32'd7, 32'd2, lat);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);
      run(5'h12, MIN, 32'hFFFF_FFFF, lat);
      chk("div_ovf_lo", lo, MIN);
      chk("div_ovf_hi", hi, 32'd0);
      run(5'h13, 32'd5, 32'd0, lat);
      chk("divu0_lo", lo, 32'hFFFF_FFFF);
      chk("divu0_hi", hi, 32'd5);
      run(5'h12, -32'd9, 32'd0, lat);
      chk("div0_hi", hi, -32'd9);

      run(5'h16, 32'h1234, 32'd0, lat);
      run(5'h17, 32'd0, 32'd0, lat);
      run(5'h15, 32'd0, 32'd0, lat);
      chk("mflo_result", result, 32'd0);
      chk1("mflo_zero", zero, 1'b1);
      run(5'h14, 32'd0, 32'd0, lat);
      chk("mfhi_result", result, 32'h1234);
      run(5'h0B, 32'd0, 32'hABCD, lat);
      chk("lui_result", result, 32'hABCD_0000);
      chk("lui_hi_kept", hi, 32'h1234);
      chk("lui_lo_kept", lo, 32'd0);

      // Randomized traffic; the per-cycle compare checks every outcome.
      for (int i = 0; i < 400; i++) begin
         issue(ops_tab[$urandom_range(0, 25)], rnd_val(), rnd_val(), k);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
